// File: rtl/idex_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// idex_hazard_ctrl_if
//   Bundles the signals between the pipeline datapath and the hazard/stall
//   controller.
//   master : pipeline side. Drives the hit/decode/hazard status and receives
//            the latch enables, flushes and status outputs.
//   slave  : controller side (idex_hazard_ctrl).
//   Status into the controller : ihit, dhit, idex_memread, idex_wsel, ifid_rs,
//                                ifid_rt, ifid_uses_rt, ex_pcsrc,
//                                exmem_memreq, memwb_halt
//   Control out of the controller: pc_en, ifid_en, ifid_flush, idex_en,
//                                idex_flush, exmem_en, memwb_en, dmem_mask,
//                                dcapture, halt_o, stall_cnt, flush_cnt
// -----------------------------------------------------------------------------
interface idex_hazard_ctrl_if #(
   parameter int CNT_W = 32
);
   logic             ihit;
   logic             dhit;
   logic             idex_memread;
   logic [4:0]       idex_wsel;
   logic [4:0]       ifid_rs;
   logic [4:0]       ifid_rt;
   logic             ifid_uses_rt;
   logic             ex_pcsrc;
   logic             exmem_memreq;
   logic             memwb_halt;

   logic             pc_en;
   logic             ifid_en;
   logic             ifid_flush;
   logic             idex_en;
   logic             idex_flush;
   logic             exmem_en;
   logic             memwb_en;
   logic             dmem_mask;
   logic             dcapture;
   logic             halt_o;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output ihit, dhit, idex_memread, idex_wsel, ifid_rs, ifid_rt,
             ifid_uses_rt, ex_pcsrc, exmem_memreq, memwb_halt,
      input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
             memwb_en, dmem_mask, dcapture, halt_o, stall_cnt, flush_cnt
   );

   modport slave (
      input  ihit, dhit, idex_memread, idex_wsel, ifid_rs, ifid_rt,
             ifid_uses_rt, ex_pcsrc, exmem_memreq, memwb_halt,
      output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
             memwb_en, dmem_mask, dcapture, halt_o, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/idex_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// idex_hazard_ctrl
//   Pipeline hazard/stall controller. Sole driver of the IF/ID, ID/EX, EX/MEM
//   and MEM/WB latch enables/flushes and of the PC enable. Resolves halt,
//   data-cache wait, taken branch/jump squash and load-use stalls (in that
//   priority), and keeps saturating stall and flush counters.
//   Ports:
//     CLK  : clock, all state updates on the rising edge
//     RST  : synchronous reset, active-high
//     bus  : idex_hazard_ctrl_if.slave (status in, latch control/counters out)
//   Parameters:
//     LU_STALL : bubbles inserted per load-use hazard (1..7)
//     CNT_W    : width of stall_cnt / flush_cnt
//   Control outputs are Mealy (state + current inputs); state and counters
//   are registered.
// -----------------------------------------------------------------------------
module idex_hazard_ctrl #(
   parameter int LU_STALL = 1,
   parameter int CNT_W    = 32
) (
   input  logic                CLK,
   input  logic                RST,
   idex_hazard_ctrl_if.slave   bus
);

   typedef enum logic [2:0] {
      RUN    = 3'd0,
      LDUSE  = 3'd1,
      DWAIT  = 3'd2,
      DDONE  = 3'd3,
      HALTED = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [2:0]       lu_q, lu_d;
   logic [CNT_W-1:0] stall_q, flush_q;

   logic mem_ok, adv, lu_hazard, halting, flush_inc, stall_inc;
   logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
   logic exmem_en, memwb_en, dmem_mask, dcapture, halt_o;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   always_comb begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      ifid_flush = 1'b0;
      idex_en    = 1'b0;
      idex_flush = 1'b0;
      exmem_en   = 1'b0;
      memwb_en   = 1'b0;
      dmem_mask  = 1'b0;
      dcapture   = 1'b0;
      halt_o     = 1'b0;
      halting    = 1'b0;
      flush_inc  = 1'b0;
      state_d    = state_q;
      lu_d       = lu_q;

      // Once DDONE, the dcache access is already complete; only ihit gates.
      mem_ok = !bus.exmem_memreq || bus.dhit || (state_q == DDONE);
      adv    = bus.ihit && mem_ok;

      // r0 is hardwired zero, so a load targeting it never creates a hazard.
      lu_hazard = bus.idex_memread && (bus.idex_wsel != 5'd0) &&
                  ((bus.idex_wsel == bus.ifid_rs) ||
                   (bus.ifid_uses_rt && (bus.idex_wsel == bus.ifid_rt)));

      if (RST) begin
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
         state_d    = RUN;
         lu_d       = 3'd0;
      end else if ((state_q == HALTED) || bus.memwb_halt) begin
         halting = 1'b1;
         halt_o  = 1'b1;
         state_d = HALTED;
      end else if ((state_q != DDONE) && bus.exmem_memreq && !bus.dhit) begin
         state_d = DWAIT;
      end else if ((state_q != DDONE) && bus.exmem_memreq && !bus.ihit) begin
         // Access finished but the front end is still waiting on the icache:
         // capture the load data now and mask further dcache requests.
         dcapture = 1'b1;
         state_d  = DDONE;
      end else if (!adv) begin
         dmem_mask = (state_q == DDONE);
      end else begin
         dmem_mask = (state_q == DDONE);
         exmem_en  = 1'b1;
         memwb_en  = 1'b1;
         if (bus.ex_pcsrc) begin
            pc_en      = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            flush_inc  = 1'b1;
            lu_d       = 3'd0;
            state_d    = RUN;
         end else if (lu_q != 3'd0) begin
            // Remaining bubbles of a multi-cycle load-use stall; a dcache
            // wait in between keeps lu_q so the count resumes afterwards.
            idex_flush = 1'b1;
            lu_d       = lu_q - 3'd1;
            state_d    = (lu_q == 3'd1) ? RUN : LDUSE;
         end else if (lu_hazard) begin
            idex_flush = 1'b1;
            if (LU_STALL > 1) begin
               lu_d    = 3'(LU_STALL - 1);
               state_d = LDUSE;
            end else begin
               state_d = RUN;
            end
         end else begin
            pc_en   = 1'b1;
            ifid_en = 1'b1;
            idex_en = 1'b1;
            state_d = RUN;
         end
      end

      stall_inc = !RST && !halting && !pc_en;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= RUN;
         lu_q    <= 3'd0;
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         state_q <= state_d;
         lu_q    <= lu_d;
         if (stall_inc) stall_q <= sat_inc(stall_q);
         if (flush_inc) flush_q <= sat_inc(flush_q);
      end
   end

   assign bus.pc_en      = pc_en;
   assign bus.ifid_en    = ifid_en;
   assign bus.ifid_flush = ifid_flush;
   assign bus.idex_en    = idex_en;
   assign bus.idex_flush = idex_flush;
   assign bus.exmem_en   = exmem_en;
   assign bus.memwb_en   = memwb_en;
   assign bus.dmem_mask  = dmem_mask;
   assign bus.dcapture   = dcapture;
   assign bus.halt_o     = halt_o;
   assign bus.stall_cnt  = stall_q;
   assign bus.flush_cnt  = flush_q;

endmodule

// File: tb/tb_idex_hazard_ctrl.sv
module tb_idex_hazard_ctrl;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct packed {
      logic       rst;
      logic       ihit;
      logic       dhit;
      logic       memread;
      logic [4:0] wsel;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       uses_rt;
      logic       pcsrc;
      logic       memreq;
      logic       halt;
   } stim_t;

   typedef struct {
      string      tag;
      int         which;
      logic [9:0] ctl;
   } exp_t;

   // ctl bit order: pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
   //                exmem_en, memwb_en, dmem_mask, dcapture, halt_o
   localparam logic [9:0] C_RST     = 10'b0010100000;
   localparam logic [9:0] C_NORM    = 10'b1101011000;
   localparam logic [9:0] C_STALL   = 10'b0000000000;
   localparam logic [9:0] C_BUB     = 10'b0000111000;
   localparam logic [9:0] C_BR      = 10'b1010111000;
   localparam logic [9:0] C_CAP     = 10'b0000000010;
   localparam logic [9:0] C_MASK    = 10'b0000000100;
   localparam logic [9:0] C_MASKADV = 10'b1101011100;
   localparam logic [9:0] C_HALT    = 10'b0000000001;

   stim_t sa, sb;
   logic  rst_a, rst_b;
   exp_t  sbq[$];
   int    checks = 0;
   int    passes = 0;
   int    fails  = 0;

   idex_hazard_ctrl_if #(.CNT_W(32)) ifa();
   idex_hazard_ctrl_if #(.CNT_W(3))  ifb();

   idex_hazard_ctrl #(.LU_STALL(1), .CNT_W(32)) dut_a (.CLK(CLK), .RST(rst_a), .bus(ifa));
   idex_hazard_ctrl #(.LU_STALL(3), .CNT_W(3))  dut_b (.CLK(CLK), .RST(rst_b), .bus(ifb));

   assign rst_a             = sa.rst;
   assign ifa.ihit          = sa.ihit;
   assign ifa.dhit          = sa.dhit;
   assign ifa.idex_memread  = sa.memread;
   assign ifa.idex_wsel     = sa.wsel;
   assign ifa.ifid_rs       = sa.rs;
   assign ifa.ifid_rt       = sa.rt;
   assign ifa.ifid_uses_rt  = sa.uses_rt;
   assign ifa.ex_pcsrc      = sa.pcsrc;
   assign ifa.exmem_memreq  = sa.memreq;
   assign ifa.memwb_halt    = sa.halt;

   assign rst_b             = sb.rst;
   assign ifb.ihit          = sb.ihit;
   assign ifb.dhit          = sb.dhit;
   assign ifb.idex_memread  = sb.memread;
   assign ifb.idex_wsel     = sb.wsel;
   assign ifb.ifid_rs       = sb.rs;
   assign ifb.ifid_rt       = sb.rt;
   assign ifb.ifid_uses_rt  = sb.uses_rt;
   assign ifb.ex_pcsrc      = sb.pcsrc;
   assign ifb.exmem_memreq  = sb.memreq;
   assign ifb.memwb_halt    = sb.halt;

   logic [9:0] oa, ob;
   assign oa = {ifa.pc_en, ifa.ifid_en, ifa.ifid_flush, ifa.idex_en, ifa.idex_flush,
                ifa.exmem_en, ifa.memwb_en, ifa.dmem_mask, ifa.dcapture, ifa.halt_o};
   assign ob = {ifb.pc_en, ifb.ifid_en, ifb.ifid_flush, ifb.idex_en, ifb.idex_flush,
                ifb.exmem_en, ifb.memwb_en, ifb.dmem_mask, ifb.dcapture, ifb.halt_o};

   function automatic stim_t st(input logic rst, input logic ihit, input logic dhit,
                                input logic memread, input logic [4:0] wsel,
                                input logic [4:0] rs, input logic [4:0] rt,
                                input logic uses_rt, input logic pcsrc,
                                input logic memreq, input logic halt);
      stim_t s;
      s.rst = rst; s.ihit = ihit; s.dhit = dhit; s.memread = memread;
      s.wsel = wsel; s.rs = rs; s.rt = rt; s.uses_rt = uses_rt;
      s.pcsrc = pcsrc; s.memreq = memreq; s.halt = halt;
      return s;
   endfunction

   // Drive one cycle of stimulus at the falling edge, queue its expected
   // Mealy outputs, then compare once the outputs have settled.
   task automatic cyc(input int which, input string tag, input stim_t s,
                      input logic [9:0] exp);
      exp_t       e;
      logic [9:0] obs;
      @(negedge CLK);
      if (which == 0) sa = s; else sb = s;
      e.tag = tag; e.which = which; e.ctl = exp;
      sbq.push_back(e);
      #1;
      e   = sbq.pop_front();
      obs = (e.which == 0) ? oa : ob;
      checks++;
      assert (obs === e.ctl) begin
         passes++;
      end else begin
         fails++;
         $error("FAIL %s: ctl observed %b expected %b", e.tag, obs, e.ctl);
      end
   endtask

   // Counters after the rising edge that closes the current cycle.
   task automatic cnt(input int which, input string tag,
                      input logic [31:0] es, input logic [31:0] ef);
      logic [31:0] os, of;
      @(posedge CLK);
      #1;
      os = (which == 0) ? ifa.stall_cnt : {29'd0, ifb.stall_cnt};
      of = (which == 0) ? ifa.flush_cnt : {29'd0, ifb.flush_cnt};
      checks++;
      assert (os === es) begin
         passes++;
      end else begin
         fails++;
         $error("FAIL %s: stall_cnt observed %0d expected %0d", tag, os, es);
      end
      checks++;
      assert (of === ef) begin
         passes++;
      end else begin
         fails++;
         $error("FAIL %s: flush_cnt observed %0d expected %0d", tag, of, ef);
      end
   endtask

   stim_t s_rst, s_idle, s_noihit, s_hz, s_mr;

   initial begin
      s_rst    = st(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      s_idle   = st(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      s_noihit = st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      s_hz     = st(0, 1, 0, 1, 5'd8, 5'd8, 0, 0, 0, 0, 0);
      s_mr     = st(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      sa = s_rst;
      sb = s_rst;

      // ---------------- instance A: LU_STALL=1, CNT_W=32 ----------------
      cyc(0, "a_rst0", s_rst, C_RST);
      cyc(0, "a_rst1", s_rst, C_RST);
      cnt(0, "a_rst_cnt", 0, 0);
      cyc(0, "a_run0", s_idle, C_NORM);
      cyc(0, "a_run1", s_idle, C_NORM);
      cnt(0, "a_run_cnt", 0, 0);

      cyc(0, "a_lu_rs", s_hz, C_BUB);
      cnt(0, "a_lu_cnt", 1, 0);
      cyc(0, "a_lu_clear", st(0, 1, 0, 0, 5'd8, 5'd8, 0, 0, 0, 0, 0), C_NORM);
      cyc(0, "a_lu_rt", st(0, 1, 0, 1, 5'd5, 5'd3, 5'd5, 1, 0, 0, 0), C_BUB);
      cyc(0, "a_rt_unused", st(0, 1, 0, 1, 5'd5, 5'd3, 5'd5, 0, 0, 0, 0), C_NORM);
      cnt(0, "a_rt_cnt", 2, 0);

      cyc(0, "a_lu_br", st(0, 1, 0, 1, 5'd8, 5'd8, 0, 0, 1, 0, 0), C_BR);
      cnt(0, "a_br_cnt", 2, 1);

      cyc(0, "a_r0", st(0, 1, 0, 1, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0), C_NORM);
      cyc(0, "a_noihit", s_noihit, C_STALL);
      cnt(0, "a_noihit_cnt", 3, 1);

      cyc(0, "a_dwait0", s_mr, C_STALL);
      cyc(0, "a_dwait1", s_mr, C_STALL);
      cyc(0, "a_dwait2", s_mr, C_STALL);
      cnt(0, "a_dwait_cnt", 6, 1);
      cyc(0, "a_dhit_noihit", st(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0), C_CAP);
      cyc(0, "a_ddone_wait", st(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), C_MASK);
      cyc(0, "a_ddone_adv", s_mr, C_MASKADV);
      cnt(0, "a_ddone_cnt", 8, 1);
      cyc(0, "a_after_dd", s_idle, C_NORM);

      cyc(0, "a_dwait_b", s_mr, C_STALL);
      cyc(0, "a_dhit_ihit", st(0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0), C_NORM);
      cnt(0, "a_dhit_ihit_cnt", 9, 1);

      cyc(0, "a_dwait_h", s_mr, C_STALL);
      cyc(0, "a_halt_in", st(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1), C_HALT);
      cyc(0, "a_halted0", s_idle, C_HALT);
      cyc(0, "a_halted1", s_idle, C_HALT);
      cyc(0, "a_halted_hz", s_hz, C_HALT);
      cyc(0, "a_rst_h", s_rst, C_RST);
      cnt(0, "a_rst_h_cnt", 0, 0);
      cyc(0, "a_post_rst", s_idle, C_NORM);

      // ---------------- instance B: LU_STALL=3, CNT_W=3 -----------------
      cyc(1, "b_rst0", s_rst, C_RST);
      cyc(1, "b_rst1", s_rst, C_RST);
      cyc(1, "b_run", s_idle, C_NORM);
      cnt(1, "b_run_cnt", 0, 0);

      cyc(1, "b_lu0", s_hz, C_BUB);
      cyc(1, "b_lu1", s_hz, C_BUB);
      cyc(1, "b_lu2", s_hz, C_BUB);
      cyc(1, "b_lu_done", st(0, 1, 0, 0, 5'd8, 5'd8, 0, 0, 0, 0, 0), C_NORM);
      cnt(1, "b_lu_cnt", 3, 0);

      cyc(1, "b_lu3", s_hz, C_BUB);
      cyc(1, "b_hold", st(0, 0, 0, 1, 5'd8, 5'd8, 0, 0, 0, 0, 0), C_STALL);
      cyc(1, "b_lu4", s_hz, C_BUB);
      cyc(1, "b_lu5", s_hz, C_BUB);
      cyc(1, "b_sat0", s_noihit, C_STALL);
      cyc(1, "b_sat1", s_noihit, C_STALL);
      cnt(1, "b_sat_cnt", 7, 0);

      cyc(1, "b_lu6", s_hz, C_BUB);
      cyc(1, "b_br_lduse", st(0, 1, 0, 0, 5'd8, 5'd8, 0, 0, 1, 0, 0), C_BR);
      cyc(1, "b_after_br", s_idle, C_NORM);
      cnt(1, "b_br_cnt", 7, 1);

      for (int i = 0; i < 8; i++)
         cyc(1, $sformatf("b_brsat%0d", i), st(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0), C_BR);
      cyc(1, "b_brsat_end", s_idle, C_NORM);
      cnt(1, "b_brsat_cnt", 7, 7);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
